// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose : shared definitions for the bit-serial adder: FSM state encoding,
//           default operand width and the bit-counter width helper.
// Ports   : none (package).
// Config  : SERIAL_ADDER_OVF_EN is consumed by serial_adder, not here.
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  // FSM state encoding. 2'd3 is never entered and decodes as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_e;

  // Default operand/result width.
  localparam int unsigned SA_WIDTH_DEF = 32'd8;

  // Bit counter width: enough to hold WIDTH-1, never less than one bit.
  function automatic int unsigned sa_cnt_width(input int unsigned w);
    int unsigned cw;
    cw = (w > 32'd1) ? $clog2(w) : 32'd1;
    if (cw < 32'd1) begin
      cw = 32'd1;
    end else begin
      cw = cw;
    end
    return cw;
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
//
// Purpose : purely combinational 1-bit full adder, the only arithmetic
//           element of the bit-serial adder.
// Ports   : x, y  - operand bits
//           ci    - carry in
//           s     - sum bit       (x ^ y ^ ci)
//           co    - carry out     (majority of x, y, ci)
// ---------------------------------------------------------------------------
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p_s;

  // Propagate term is shared between the sum and the carry.
  assign p_s = x ^ y;
  assign s   = p_s ^ ci;
  assign co  = (x & y) | (ci & p_s);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Purpose : bit-serial WIDTH-bit adder. Operands are shifted LSB-first through
//           a single fa_cell with a registered carry, one bit per clock.
//           {cout,sum} = a + b + cin. Result is held until the next accepted
//           start.
//
// Ports   : clk   - rising-edge clock
//           rst   - synchronous reset, active-high (wins over start)
//           start - begin an addition; only honoured while ready=1
//           a, b  - WIDTH-bit operands, captured on the accepting edge
//           cin   - carry in, captured on the accepting edge
//           ready - high in IDLE
//           busy  - high while bits are being shifted
//           done  - one-cycle pulse when sum/cout/ovf become valid
//           sum   - result (partial during shifting, valid from done)
//           cout  - final carry out, held with sum
//           ovf   - signed overflow, held with sum
//
// Config  : `define SERIAL_ADDER_OVF_EN builds the signed-overflow flag.
//           Without it ovf is tied low and no extra flop exists; the port
//           list is identical either way.
//
// Timing  : accept edge E0 -> WIDTH shift edges -> done high in the cycle
//           after E0+WIDTH -> ready again after E0+WIDTH+1.
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = sa_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 32'd1);

  // Architectural state.
  sa_state_e        state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  // Next values of the shifting datapath.
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] sum_d;
  logic [CNT_W-1:0] cnt_d;

  // Cell outputs and decodes.
  logic fa_s;
  logic fa_co;
  logic cnt_last_s;
  logic shift_s;
  logic accept_s;

  fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Shift-datapath next values and state decodes.
  always_comb begin
    a_d        = {1'b0, a_q[WIDTH-1:1]};
    b_d        = {1'b0, b_q[WIDTH-1:1]};
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    sum_d      = {fa_s, sum_q[WIDTH-1:1]};
    cnt_last_s = (cnt_q == CNT_LAST);
    shift_s    = (state_q == ST_SHIFT);
    // Both IDLE and the unused code 2'd3 behave as IDLE.
    accept_s   = (state_q != ST_SHIFT) && (state_q != ST_DONE) && start;
    if (cnt_last_s) begin
      // Hold at WIDTH-1 instead of wrapping on the final shift.
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sequencer FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_SHIFT: begin
          a_q     <= a_d;
          b_q     <= b_d;
          sum_q   <= sum_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_d;
          if (cnt_last_s) begin
            state_q <= ST_DONE;
            cout_q  <= fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          // Start is ignored here; always return to IDLE.
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          // ST_IDLE, and the unreachable code 2'd3 treated the same way.
          if (start) begin
            state_q <= ST_SHIFT;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: carry_q on the last shift edge is the carry into the
  // MSB (produced on the second-to-last edge); XOR with the final carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept_s) begin
      ovf_q <= 1'b0;
    end else if (shift_s && cnt_last_s) begin
      ovf_q <= carry_q ^ fa_co;
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign ovf = ovf_q;
`else
  // Feature disabled: flag tied low, decodes only feed the enabled build.
  logic unused_ovf_s;
  assign unused_ovf_s = accept_s ^ shift_s;
  assign ovf          = 1'b0;
`endif

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=13.
// Expected results come from a behavioural a+b+cin model, pushed to a
// per-instance queue on issue and popped when done is seen.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, cin8, ready8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, cin13, ready13, busy13, done13, cout13, ovf13;
  logic [12:0] a13, b13, sum13;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0]  q8[$];   // {ovf, cout, sum}
  logic [14:0] q13[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .ready(ready13), .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .ovf(ovf13)
  );

  function automatic logic [9:0] model8(input logic [7:0] aa, input logic [7:0] bb, input logic cc);
    logic [8:0] t;
    logic       ov;
    t = {1'b0, aa} + {1'b0, bb} + {8'd0, cc};
`ifdef SERIAL_ADDER_OVF_EN
    ov = (aa[7] == bb[7]) && (t[7] != aa[7]);
`else
    ov = 1'b0;
`endif
    return {ov, t};
  endfunction

  function automatic logic [14:0] model13(input logic [12:0] aa, input logic [12:0] bb, input logic cc);
    logic [13:0] t;
    logic        ov;
    t = {1'b0, aa} + {1'b0, bb} + {13'd0, cc};
`ifdef SERIAL_ADDER_OVF_EN
    ov = (aa[12] == bb[12]) && (t[12] != aa[12]);
`else
    ov = 1'b0;
`endif
    return {ov, t};
  endfunction

  // Wait (bounded) for ready, pulse start for one edge, record expectation.
  task automatic issue8(input logic [7:0] aa, input logic [7:0] bb, input logic cc);
    int n = 0;
    while (ready8 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (ready8 !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL issue8_ready_timeout: ready=%b required 1", ready8);
    end
    a8 = aa; b8 = bb; cin8 = cc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    q8.push_back(model8(aa, bb, cc));
  endtask

  task automatic issue13(input logic [12:0] aa, input logic [12:0] bb, input logic cc);
    int n = 0;
    while (ready13 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (ready13 !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL issue13_ready_timeout: ready=%b required 1", ready13);
    end
    a13 = aa; b13 = bb; cin13 = cc; start13 = 1'b1;
    @(posedge clk); #1;
    start13 = 1'b0;
    q13.push_back(model13(aa, bb, cc));
  endtask

  // Count edges after the accept edge until done is observed (bounded).
  task automatic wait_done8(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (done8 !== 1'b1 && lat < 200);
    if (done8 !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL done8_timeout: done=%b required 1", done8);
    end
  endtask

  task automatic wait_done13(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (done13 !== 1'b1 && lat < 200);
    if (done13 !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL done13_timeout: done=%b required 1", done13);
    end
  endtask

  task automatic test_reset();
    // rst and start high together: reset must win.
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start13 = 1'b1; a13 = 13'h1FFF; b13 = 13'h1FFF; cin13 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if ({ready8, busy8, done8, cout8, ovf8} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_flags8: rdy/bsy/dn/co/ov=%b required 10000", {ready8, busy8, done8, cout8, ovf8});
    end
    tests_run++;
    if (sum8 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_sum8: got %h required 00", sum8);
    end
    tests_run++;
    if ({ready13, busy13, done13, cout13, ovf13, sum13} !== {5'b10000, 13'h0}) begin
      tests_failed++;
      $display("FAIL reset_13: flags=%b sum=%h required 10000/0000", {ready13, busy13, done13, cout13, ovf13}, sum13);
    end
    start8 = 1'b0; start13 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int         lat;
    logic [9:0] exp;
    logic [7:0] ta [3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'hFF};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] fixed [3] = '{9'h010, 9'h100, 9'h1FF};
    for (int i = 0; i < 3; i++) begin
      issue8(ta[i], tb[i], tc[i]);
      wait_done8(lat);
      exp = q8.pop_front();
      tests_run++;
      if ({cout8, sum8} !== fixed[i]) begin
        tests_failed++;
        $display("FAIL basic_result[%0d]: got %h required %h", i, {cout8, sum8}, fixed[i]);
      end
      tests_run++;
      if (ovf8 !== exp[9]) begin
        tests_failed++;
        $display("FAIL basic_ovf[%0d]: got %b required %b", i, ovf8, exp[9]);
      end
      if (i == 0) begin
        tests_run++;
        if (lat !== 8) begin
          tests_failed++;
          $display("FAIL basic_latency: got %0d edges required 8", lat);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({ready8, done8, busy8} !== 3'b100) begin
          tests_failed++;
          $display("FAIL basic_ready_after_done: rdy/dn/bsy=%b required 100", {ready8, done8, busy8});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if ({cout8, sum8} !== 9'h010) begin
          tests_failed++;
          $display("FAIL basic_hold: got %h required 010", {cout8, sum8});
        end
      end
    end
  endtask

  task automatic test_ovf();
    int         lat;
    logic [9:0] exp;
    logic [7:0] ta [3] = '{8'h7F, 8'h80, 8'h10};
    logic [7:0] tb [3] = '{8'h01, 8'h80, 8'h20};
    for (int i = 0; i < 3; i++) begin
      issue8(ta[i], tb[i], 1'b0);
      wait_done8(lat);
      exp = q8.pop_front();
      tests_run++;
      if ({ovf8, cout8, sum8} !== exp) begin
        tests_failed++;
        $display("FAIL ovf_case[%0d]: got ovf/cout/sum=%h required %h", i, {ovf8, cout8, sum8}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         dones = 0;
    int         lat;
    logic [8:0] seen = 9'h000;
    logic [9:0] exp;
    while (ready8 !== 1'b1 && dones < 50) begin
      @(posedge clk); #1; dones++;
    end
    dones = 0;
    a8 = 8'h05; b8 = 8'h03; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model8(8'h05, 8'h03, 1'b0));
    a8 = 8'hAA; b8 = 8'h55;   // start stays high through SHIFT and DONE
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        dones++;
        seen = {cout8, sum8};
      end
    end
    exp = q8.pop_front();
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL b2b_done_count: got %0d pulses required 1", dones);
    end
    tests_run++;
    if (seen !== exp[8:0]) begin
      tests_failed++;
      $display("FAIL b2b_first_result: got %h required %h", seen, exp[8:0]);
    end
    tests_run++;
    if ({ready8, busy8} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_ready_returns: rdy/bsy=%b required 10", {ready8, busy8});
    end
    @(posedge clk); #1;
    q8.push_back(model8(8'hAA, 8'h55, 1'b0));
    start8 = 1'b0;
    tests_run++;
    if ({ready8, busy8} !== 2'b01) begin
      tests_failed++;
      $display("FAIL b2b_second_accept: rdy/bsy=%b required 01", {ready8, busy8});
    end
    wait_done8(lat);
    exp = q8.pop_front();
    tests_run++;
    if ({cout8, sum8} !== exp[8:0] || lat !== 8) begin
      tests_failed++;
      $display("FAIL b2b_second_result: got %h lat %0d required %h lat 8", {cout8, sum8}, lat, exp[8:0]);
    end
  endtask

  task automatic test_abort();
    int         dones = 0;
    int         lat;
    logic [9:0] exp;
    issue8(8'hC3, 8'h5A, 1'b1);     // now in SHIFT cycle 1
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;           // reach SHIFT cycle 4
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(q8.pop_back());
    tests_run++;
    if ({ready8, busy8, done8, cout8, ovf8, sum8} !== {5'b10000, 8'h00}) begin
      tests_failed++;
      $display("FAIL abort_state: flags=%b sum=%h required 10000/00", {ready8, busy8, done8, cout8, ovf8}, sum8);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d pulses required 0", dones);
    end
    issue8(8'h12, 8'h34, 1'b0);
    wait_done8(lat);
    exp = q8.pop_front();
    tests_run++;
    if ({ovf8, cout8, sum8} !== exp) begin
      tests_failed++;
      $display("FAIL abort_recover: got %h required %h", {ovf8, cout8, sum8}, exp);
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [9:0]  exp8;
    logic [14:0] exp13;
    for (int i = 0; i < 1000; i++) begin
      issue8(8'($urandom()), 8'($urandom()), 1'($urandom()));
      wait_done8(lat);
      exp8 = q8.pop_front();
      tests_run++;
      if ({ovf8, cout8, sum8} !== exp8 || lat !== 8) begin
        tests_failed++;
        $display("FAIL rand8[%0d]: got %h lat %0d required %h lat 8", i, {ovf8, cout8, sum8}, lat, exp8);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand8_pulse[%0d]: done=%b required 0", i, done8);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      issue13(13'($urandom()), 13'($urandom()), 1'($urandom()));
      wait_done13(lat);
      exp13 = q13.pop_front();
      tests_run++;
      if ({ovf13, cout13, sum13} !== exp13 || lat !== 13) begin
        tests_failed++;
        $display("FAIL rand13[%0d]: got %h lat %0d required %h lat 13", i, {ovf13, cout13, sum13}, lat, exp13);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done13 !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand13_pulse[%0d]: done=%b required 0", i, done13);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start13 = 1'b0; a13 = 13'h0; b13 = 13'h0; cin13 = 1'b0;
    test_reset();
    test_basic();
    test_ovf();
    test_back_to_back();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around a single 1-bit full-adder cell and a registered carry. It accepts two operands and a carry-in with a start/done handshake. Operands are shifted LSB-first through the cell, one bit per clock. The result and carry-out are held until the next operation. This is the area-minimal alternative to a ripple array of full-adder cells, for datapaths where latency is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request to begin an addition; sampled only when ready=1
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
ready  output  1  high in IDLE; block can accept start
busy  output  1  high while bits are being shifted
done  output  1  one-cycle pulse when the result becomes valid
sum  output  WIDTH  result; held stable from done until the next accepted start
cout  output  1  final carry-out; held with sum
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). These are fixed.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0. Bit counter, operand shift registers and carry register are all 0.
- States and transitions:
  - IDLE: ready=1. If start=1, at the edge (E0) load a and b into the shift registers, load cin into the carry register, clear the counter, clear sum, and go to SHIFT.
  - SHIFT: busy=1, ready=0. Each edge:
    - the full-adder cell takes the LSB of A, the LSB of B and the carry register;
    - the sum bit enters the MSB of the sum register, which shifts right;
    - the carry register takes the cell's carry;
    - the A and B registers shift right;
    - the counter increments.
  - Leaving SHIFT: on the edge where counter==WIDTH-1 (edge E0+WIDTH), go to DONE. cout takes the final carry at that same edge.
  - DONE: done=1 for exactly one cycle, busy=0, ready=0. Unconditionally go to IDLE on the next edge.
- Latency: done is high during the cycle after edge E0+WIDTH. ready returns at edge E0+WIDTH+1. Minimum issue interval is WIDTH+2 cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No truncation or sign extension.
- start while busy, or in DONE, is ignored. There is no queueing, and operands on a/b/cin are not sampled.
- a, b and cin may change freely after the accepting edge without affecting the result.
- sum and cout are not valid during SHIFT: sum holds partial bits. The consumer uses them only at or after done.
- rst asserted mid-operation aborts the operation. All registers return to their reset values at that edge, and no done pulse is issued.
- rst and start high together: rst wins.
- The counter is $clog2(WIDTH) bits wide, minimum 1, and never wraps past WIDTH-1.

Optional Feature:
Macro: SERIAL_ADDER_OVF_EN.
- Defined: the carry into the MSB position is captured on the second-to-last shift edge. At the DONE transition, ovf = carry-into-MSB XOR final carry. ovf is held with sum and cleared by reset and by an accepted start.
- Undefined: ovf is tied to 0 and no extra flops are built. The port list is identical in both cases.

Decomposition:
- Package serial_adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2 (2'd3 unreachable; decodes to IDLE);
  - default width constant SA_WIDTH_DEF=8.
- One sub-module, fa_cell: purely combinational 1-bit full adder with inputs x, y, ci and outputs s, co. Instantiated once. All sequencing lives in serial_adder.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulse → done exactly 8 edges after the accept edge; sum=8'h10, cout=0; ready high on the next cycle.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- With SERIAL_ADDER_OVF_EN defined:
  - a=8'h7F, b=8'h01 → sum=8'h80, ovf=1;
  - a=8'h80, b=8'h80 → sum=8'h00, cout=1, ovf=1;
  - a=8'h10, b=8'h20 → ovf=0.
  Without the macro, ovf=0 in all three cases.
- Start a=8'h05, b=8'h03. Hold start high and change a/b to 8'hAA/8'h55 during SHIFT and DONE → only one done pulse; sum=8'h08. The second operation starts only on the edge after ready returns.
- Assert rst for one cycle at the 4th SHIFT cycle → no done pulse; ready=1, sum=0, cout=0 after the reset edge. A new start then completes normally.
- Random sweep of 1000 operand pairs at WIDTH=8 and WIDTH=13 → {cout,sum} matches a+b+cin every time; done pulse width is exactly 1 cycle.
